mainfsm: RTL
============

# mainfsm

Main control state machine for the multicycle RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath mux selects and write enables, and produces the 2-bit ALUOp consumed by the ALU decoder (aludec). Memory accesses use a single-signal ready handshake, so the FSM stalls on slow memory.

## Interface
- Parameters: none.
- clk  in  1  core clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  7  instruction opcode (Instr[6:0]), valid from the cycle after IRWrite.
- MemReady  in  1  memory handshake; the access completes in a cycle where this is high.
- PCUpdate  out  1  PC register write enable.
- Branch  out  1  branch-evaluate; the datapath ORs Branch&Zero into the PC enable.
- IRWrite  out  1  instruction/OldPC register write enable.
- RegWrite  out  1  register file write enable.
- MemWrite  out  1  data memory write strobe.
- AdrSrc  out  1  memory address select: 0=PC, 1=Result.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1.
- ALUSrcB  out  2  00=WriteData, 01=ImmExt, 10=constant 4.
- ALUOp  out  2  00=add, 01=sub, 10=funct-decoded (to aludec).
- InstrDone  out  1  one-cycle pulse when an instruction retires.
- Illegal  out  1  high while in TRAP.

## Operation
- Outputs are decoded from the state register (Moore), with one exception: FETCH IRWrite/PCUpdate are gated by MemReady.
- Signals not listed for a state are 0; selects not listed are 00.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, IRWrite=PCUpdate=MemReady. Go to DECODE when MemReady=1, else stay.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other value → TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Stay until MemReady=1, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1. Go to FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 (held until accepted). On MemReady=1: InstrDone=1, go to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1. Go to FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, InstrDone=1. Go to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Go to ALUWB.
- TRAP: Illegal=1, all enables 0. Leave only on reset.

## Timing
- Reset:
  - reset sampled high → state=FETCH on that edge, from any state, including mid-stall in MEMREAD/MEMWRITE.
  - While reset is high, PCUpdate, IRWrite, RegWrite, MemWrite, Branch, InstrDone and Illegal are forced 0.
  - While reset is high, selects show FETCH values: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
- Latency with zero wait states, fetch to InstrDone inclusive:
  - lw 5 cycles
  - sw 4, R-type 4, I-type 4, jal 4
  - beq 3
- Each cycle of MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- op is ignored outside DECODE and MEMADR.
- InstrDone is asserted exactly once per retired instruction; never in TRAP.
- MemWrite must not be deasserted before MemReady is seen.

## Structure
- riscv_pkg holds:
  - statetype enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
  - Opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL.
  - Select encodings: ALUOP_ADD/SUB/FUNCT, SRCA_*, SRCB_*, RES_*.
- Single module, no sub-module.
- Integration: a controller wrapper instantiates mainfsm alongside aludec and the immediate-select decoder.

## Test plan
- Reset for 2 cycles, MemReady=1 → FETCH outputs with all enables 0 during reset; IRWrite=PCUpdate=1 in the first cycle after reset.
- op=0110011, MemReady=1 → FETCH, DECODE, EXECR (ALUOp=10, ALUSrcB=00), ALUWB (RegWrite=1, InstrDone=1); back in FETCH on cycle 5.
- op=0000011, MemReady low for 3 cycles in MEMREAD → 8 total cycles; RegWrite=1 with ResultSrc=01 exactly once.
- op=0100011 with MemReady low for 2 cycles in MEMWRITE → MemWrite held 3 cycles, single InstrDone, no RegWrite.
- op=1100011 → BEQ with ALUOp=01, Branch=1; 3-cycle instruction. op=1101111 → JAL with PCUpdate=1, then ALUWB RegWrite=1.
- op=1111111 → TRAP with Illegal=1 held for 10 cycles, no enables. Then reset pulse → FETCH, Illegal=0. Reset asserted mid-MEMREAD → FETCH next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states,
// major opcodes and datapath select encodings.
// Ports: none (package only).
package riscv_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
  } statetype;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_WD    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/mainfsm.sv
// Main control FSM of the multicycle RV32I core: fetch/decode/execute/mem/writeback.
// Latency: lw 5, sw/R/I/jal 4, beq 3 cycles with zero wait states.
// Backpressure: stalls in FETCH, MEMREAD and MEMWRITE while MemReady is low.
// Ports: clk, reset (sync, active-high), op (Instr[6:0]), MemReady (memory
// handshake) in; PC/IR/regfile/memory enables, datapath selects, ALUOp,
// InstrDone retire pulse and Illegal (TRAP) out.
module mainfsm
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       MemReady,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       InstrDone,
  output logic       Illegal
);

  statetype state_q, state_d;
  statetype s;  // state used for output decode

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (MemReady) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = TRAP;
        endcase
      end
      MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (MemReady) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (MemReady) state_d = FETCH;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      JAL:      state_d = ALUWB;
      TRAP:     state_d = TRAP;
      default:  state_d = TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Output decode. While reset is high the selects present FETCH values
  // immediately (the register has not been cleared yet), and all enables
  // are suppressed below.
  assign s = reset ? FETCH : state_q;

  always_comb begin
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_WD;
    ALUOp     = ALUOP_ADD;
    InstrDone = 1'b0;
    Illegal   = 1'b0;
    case (s)
      FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        // PC+4 and the instruction are only captured once memory delivers.
        IRWrite   = MemReady;
        PCUpdate  = MemReady;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        MemWrite  = 1'b1;
        InstrDone = MemReady;  // retires in the cycle the store is accepted
      end
      EXECR: begin
        ALUSrcA = SRCA_RD1;
        ALUOp   = ALUOP_FUNCT;
      end
      EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      ALUWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      BEQ: begin
        ALUSrcA   = SRCA_RD1;
        ALUOp     = ALUOP_SUB;
        Branch    = 1'b1;
        InstrDone = 1'b1;
      end
      JAL: begin
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        PCUpdate = 1'b1;
      end
      TRAP:    Illegal = 1'b1;
      default: Illegal = 1'b1;
    endcase
    if (reset) begin
      PCUpdate  = 1'b0;
      Branch    = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
      InstrDone = 1'b0;
      Illegal   = 1'b0;
    end
  end

endmodule
